// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit core: widths, instruction field
// positions and the fetch-stage state encoding.
package isa_pkg;

    localparam int unsigned INST_W    = 16;
    localparam int unsigned ADDR_W    = 16;

    localparam int unsigned OPCODE_HI = 15;
    localparam int unsigned OPCODE_LO = 11;
    localparam int unsigned RD_HI     = 10;
    localparam int unsigned RD_LO     = 8;
    localparam int unsigned RS_HI     = 7;
    localparam int unsigned RS_LO     = 5;
    localparam int unsigned RT_HI     = 4;
    localparam int unsigned RT_LO     = 2;
    localparam int unsigned IMM_HI    = 4;
    localparam int unsigned IMM_LO    = 0;

    localparam int unsigned OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;
    localparam int unsigned REG_W     = RD_HI - RD_LO + 1;
    localparam int unsigned IMM_W     = 5;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_HOLD  = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_e;

    // Word-addressed increment; wraps from all-ones to zero.
    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch stage
// (master) and instruction memory (slave).
interface instr_fetch_if;

    logic                        req;
    logic [isa_pkg::ADDR_W-1:0]  addr;
    logic                        ack;
    logic [isa_pkg::INST_W-1:0]  rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/inst_fields.sv
// Combinational slicer of an instruction word into its decode fields;
// shared by fetch and decode.
module inst_fields
    import isa_pkg::*;
(
    input  logic [INST_W-1:0]   inst,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [IMM_W-1:0]    imm5
);

    assign opcode = inst[OPCODE_HI:OPCODE_LO];
    assign rd     = inst[RD_HI:RD_LO];
    assign rs     = inst[RS_HI:RS_LO];
    assign rt     = inst[RT_HI:RT_LO];
    assign imm5   = inst[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches one word at a time over the imem bus,
// holds it for decode and handles redirects from branch resolution.
module instr_fetch
    import isa_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_if.master       imem,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_W-1:0]   inst,
    output logic [ADDR_W-1:0]   inst_pc,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [IMM_W-1:0]    imm5
);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   flush_addr_q;
    logic [INST_W-1:0]   inst_q;
    logic [ADDR_W-1:0]   inst_pc_q;
    logic                inst_valid_q, inst_valid_d;
    logic                capture;
    logic                enter_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect outranks everything; an in-flight request must still
    // complete, so a redirect without ack parks in FLUSH on the stale address.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        capture      = 1'b0;
        enter_flush  = 1'b0;
        case (state_q)
            FETCH_REQ: begin
                if (redirect_valid) begin
                    pc_d         = redirect_pc;
                    inst_valid_d = 1'b0;
                    if (!imem.ack) begin
                        state_d     = FETCH_FLUSH;
                        enter_flush = 1'b1;
                    end
                end else if (imem.ack) begin
                    capture      = 1'b1;
                    pc_d         = pc_next(pc_q);
                    inst_valid_d = 1'b1;
                    state_d      = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (redirect_valid) begin
                    pc_d         = redirect_pc;
                    inst_valid_d = 1'b0;
                    state_d      = FETCH_REQ;
                end else if (inst_valid_q && inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = FETCH_REQ;
                end
            end
            FETCH_FLUSH: begin
                if (redirect_valid) begin
                    pc_d         = redirect_pc;
                    inst_valid_d = 1'b0;
                end
                if (imem.ack) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d      = FETCH_REQ;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            flush_addr_q <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            if (enter_flush) begin
                flush_addr_q <= pc_q;
            end
            if (capture) begin
                inst_q    <= imem.rdata;
                inst_pc_q <= pc_q;
            end
        end
    end

    // Request drops combinationally with reset so an abandoned fetch ends at once.
    assign imem.req  = rst_n && (state_q != FETCH_HOLD);
    assign imem.addr = (state_q == FETCH_FLUSH) ? flush_addr_q : pc_q;

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    inst_fields u_inst_fields (
        .inst   (inst_q),
        .opcode (opcode),
        .rd     (rd),
        .rs     (rs),
        .rt     (rt),
        .imm5   (imm5)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: the bench acts as instruction memory and
// a scoreboard monitor checks every instruction consumed by decode.
module tb_instr_fetch;
    import isa_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int unsigned delay;
        logic [4:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [4:0]  imm;
    } vec_t;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
        logic [4:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [4:0]  imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [4:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [4:0]  imm5;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    vec_t vecs[8];

    instr_fetch_if imem_bus ();

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .rd             (rd),
        .rs             (rs),
        .rt             (rt),
        .imm5           (imm5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumption happens when valid & ready and no redirect wins that cycle.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_inst: got %h pc %h expected no instruction", inst, inst_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_inst",   inst,          e.inst);
                chk("sb_pc",     inst_pc,       e.pc);
                chk("sb_opcode", 16'(opcode),   16'(e.op));
                chk("sb_rd",     16'(rd),       16'(e.rd));
                chk("sb_rs",     16'(rs),       16'(e.rs));
                chk("sb_rt",     16'(rt),       16'(e.rt));
                chk("sb_imm5",   16'(imm5),     16'(e.imm));
            end
        end
    end

    task automatic fetch(input vec_t v, input bit push);
        int unsigned n = 0;
        while (!imem_bus.req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("req@%h", v.addr), 16'(imem_bus.req), 16'd1);
        chk("fetch_addr", imem_bus.addr, v.addr);
        for (int unsigned i = 0; i < v.delay; i++) begin
            @(posedge clk); #1;
            chk("wait_req",   16'(imem_bus.req), 16'd1);
            chk("wait_addr",  imem_bus.addr, v.addr);
            chk("wait_valid", 16'(inst_valid), 16'd0);
        end
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = v.data;
        @(posedge clk); #1;
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = '0;
        chk("cap_valid", 16'(inst_valid), 16'd1);
        chk("cap_req",   16'(imem_bus.req), 16'd0);
        chk("cap_inst",  inst, v.data);
        if (push) begin
            sb.push_back('{inst: v.data, pc: v.addr, op: v.op, rd: v.rd,
                           rs: v.rs, rt: v.rt, imm: v.imm});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h0000, 16'hC018, 0, 5'h18, 3'd0, 3'd0, 3'd6, 5'h18};
        vecs[1] = '{16'h0001, 16'h5A5F, 3, 5'h0B, 3'd2, 3'd2, 3'd7, 5'h1F};
        vecs[2] = '{16'h0002, 16'h2467, 0, 5'h04, 3'd4, 3'd3, 3'd1, 5'h07};
        vecs[3] = '{16'h0003, 16'h8B94, 0, 5'h11, 3'd3, 3'd4, 3'd5, 5'h14};
        vecs[4] = '{16'h0004, 16'hFFFF, 0, 5'h1F, 3'd7, 3'd7, 3'd7, 5'h1F};
        vecs[5] = '{16'h0040, 16'h1111, 0, 5'h02, 3'd1, 3'd0, 3'd4, 5'h11};
        vecs[6] = '{16'hFFFF, 16'h7AC3, 0, 5'h0F, 3'd2, 3'd6, 3'd0, 5'h03};
        vecs[7] = '{16'h0000, 16'h3E2D, 1, 5'h07, 3'd6, 3'd1, 3'd3, 5'h0D};

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",     16'(imem_bus.req), 16'd0);
        chk("rst_valid",   16'(inst_valid), 16'd0);
        chk("rst_inst",    inst, 16'h0000);
        chk("rst_inst_pc", inst_pc, 16'h0000);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req",  16'(imem_bus.req), 16'd1);
        chk("post_rst_addr", imem_bus.addr, 16'h0000);

        // First fetch, then decode stalls for 5 cycles
        fetch(vecs[0], 1'b1);
        chk("first_opcode",  16'(opcode), 16'h0018);
        chk("first_imm5",    16'(imm5), 16'h0018);
        chk("first_inst_pc", inst_pc, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", 16'(inst_valid), 16'd1);
            chk("stall_inst",  inst, 16'hC018);
            chk("stall_req",   16'(imem_bus.req), 16'd0);
        end
        inst_ready = 1'b1;
        @(posedge clk); #1;

        // Slow memory, then back-to-back fetches with ready held high
        fetch(vecs[1], 1'b1);
        fetch(vecs[2], 1'b1);
        @(posedge clk); #1;
        chk("tput_req",  16'(imem_bus.req), 16'd1);
        chk("tput_addr", imem_bus.addr, 16'h0003);
        fetch(vecs[3], 1'b1);
        fetch(vecs[4], 1'b1);
        @(posedge clk); #1;
        chk("pre_redir_req",  16'(imem_bus.req), 16'd1);
        chk("pre_redir_addr", imem_bus.addr, 16'h0005);

        // Redirect with a request outstanding: stale ack must be dropped
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("flush_req",   16'(imem_bus.req), 16'd1);
        chk("flush_addr",  imem_bus.addr, 16'h0005);
        chk("flush_valid", 16'(inst_valid), 16'd0);
        @(posedge clk); #1;
        chk("flush_addr_hold", imem_bus.addr, 16'h0005);
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 16'hDEAD;
        @(posedge clk); #1;
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = '0;
        chk("stale_valid", 16'(inst_valid), 16'd0);
        chk("redir_req",   16'(imem_bus.req), 16'd1);
        chk("redir_addr",  imem_bus.addr, 16'h0040);

        // Redirect in HOLD while ready is high: held instruction is dropped
        fetch(vecs[5], 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("hold_redir_valid", 16'(inst_valid), 16'd0);
        chk("hold_redir_req",   16'(imem_bus.req), 16'd1);
        chk("hold_redir_addr",  imem_bus.addr, 16'hFFFF);

        // Fetch at the top of memory, PC wraps to zero
        fetch(vecs[6], 1'b1);
        fetch(vecs[7], 1'b1);
        @(posedge clk); #1;
        chk("after_wrap_addr", imem_bus.addr, 16'h0001);

        // Reset asserted mid-request
        rst_n = 1'b0;
        #1;
        chk("midrst_req",   16'(imem_bus.req), 16'd0);
        chk("midrst_valid", 16'(inst_valid), 16'd0);
        chk("midrst_inst",  inst, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rerst_req",  16'(imem_bus.req), 16'd1);
        chk("rerst_addr", imem_bus.addr, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the 16-bit ISA core: owns the program counter, fetches one 16-bit instruction word at a time from instruction memory over a req/ack handshake, and holds it in an instruction register. It presents the instruction and its pre-sliced fields (opcode, register indices, 5-bit immediate) to decode. The 5-bit immediate output drives the sign-extension stage directly. Redirects from branch/jump resolution reload the PC and discard any stale fetch.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  16  word address of the fetch; stable while imem_req=1
- imem_ack  in  1  one-cycle pulse: imem_rdata valid this cycle
- imem_rdata  in  16  fetched instruction word
- redirect_valid  in  1  one-cycle pulse: load redirect_pc
- redirect_pc  in  16  new PC target
- inst_valid  out  1  instruction register holds a valid instruction
- inst_ready  in  1  decode accepts the instruction this cycle
- inst  out  16  instruction register
- inst_pc  out  16  address the held instruction came from
- opcode  out  5  inst[15:11]
- rd  out  3  inst[10:8]
- rs  out  3  inst[7:5]
- rt  out  3  inst[4:2]
- imm5  out  5  inst[4:0], feeds sign extension

## Operation
- States: REQ, HOLD, FLUSH. Reset state REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: inst<=imem_rdata, inst_pc<=pc, pc<=pc+1, inst_valid<=1, go HOLD.
- HOLD: imem_req=0. On inst_valid & inst_ready: inst_valid<=0, go REQ.
- FLUSH: imem_req=1, imem_addr=stale address (unchanged). On imem_ack: data discarded, go REQ (new pc already loaded).
- Redirect (highest priority, any state): pc<=redirect_pc, inst_valid<=0.
  - In REQ without ack same cycle: go FLUSH (request already in flight must complete).
  - In REQ with ack same cycle: fetched data discarded, go REQ.
  - In HOLD: go REQ (held instruction dropped even if inst_ready=1 that cycle).
  - In FLUSH: pc updated again, remain FLUSH.
- PC arithmetic: 16-bit, word addressed, 16'hFFFF + 1 wraps to 16'h0000.
- Field outputs are pure slices of inst; valid only when inst_valid=1.
- One outstanding memory request maximum.

## Timing
- Reset (async assert, sync to clk on deassert): pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, state REQ; imem_req=0 while rst_n=0, 1 in first cycle after release.
- Fetch latency: ack in cycle N -> inst_valid=1 in cycle N+1.
- Throughput: with ack in request's first cycle and inst_ready tied high, one instruction per 2 cycles.
- Redirect in cycle N -> imem_addr=redirect_pc from cycle N+1 (REQ/HOLD) or cycle after stale ack (FLUSH).
- Reset asserted mid-fetch: request abandoned immediately, no ack expected thereafter; memory must tolerate.

## Structure
- Shared package isa_pkg: INST_W=16, ADDR_W=16, field bit positions (OPCODE_HI/LO, RD_*, RS_*, RT_*, IMM_HI/LO), IMM_W=5, fetch state enum.
- One natural sub-module: inst_fields (combinational slicer of inst into opcode/rd/rs/rt/imm5), reused by decode.
- Top instantiates instr_fetch feeding inst_fields; imm5 goes to the sign-extension stage.

## Test plan
- Reset release, RESET_PC=0, memory acks same cycle with 16'hC018 -> imem_addr=0, next cycle inst_valid=1, inst=16'hC018, opcode=5'b11000, imm5=5'b11000, inst_pc=0, pc=1.
- inst_ready low 5 cycles in HOLD -> inst/inst_valid stable, imem_req=0; ready high -> next REQ at addr 1.
- Memory ack delayed 3 cycles -> imem_addr stays constant, imem_req high throughout; instruction captured on ack only.
- Redirect to 16'h0040 while request to 16'h0005 outstanding -> FLUSH, stale ack data dropped (inst_valid stays 0), next request addr 16'h0040.
- Redirect in HOLD with inst_ready=1 same cycle -> held instruction not consumed-valid next cycle, next fetch at target.
- Fetch at 16'hFFFF -> inst_pc=16'hFFFF, next imem_addr=16'h0000.
